// File: rtl/product_acc_pkg.sv
// Shared definitions for the product accumulator.
// Contents:
//   acc_state_e      - group FSM state (no beats / one or more beats)
//   *_W_DEF          - default widths for product, accumulator and beat counter
//   SAT_MAX_DEF/MIN  - saturation bounds at the default accumulator width
package product_acc_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } acc_state_e;

    localparam int unsigned PROD_W_DEF = 64;
    localparam int unsigned ACC_W_DEF  = 72;
    localparam int unsigned CNT_W_DEF  = 16;

    // Largest positive / most negative two's-complement value at ACC_W_DEF.
    localparam logic [ACC_W_DEF-1:0] SAT_MAX_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] SAT_MIN_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/acc_add_ovf.sv
// Combinational ACC_W-wide signed adder with overflow detection.
// Configuration macro: PRODUCT_ACC_SAT_EN - when defined, an overflowing sum
// clamps to the most positive / most negative value instead of wrapping.
// Ports:
//   acc  in  ACC_W  current accumulator value (signed)
//   prod in  ACC_W  sign-extended product (signed)
//   sum  out ACC_W  acc + prod (wrapped or clamped)
//   ovf  out 1      signed overflow occurred on this addition
module acc_add_ovf
    import product_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] prod,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W-1:0] sum_raw;

    assign sum_raw = acc + prod;
    // Like-signed operands producing a result of the opposite sign.
    assign ovf = (acc[ACC_W-1] == prod[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef PRODUCT_ACC_SAT_EN
    logic [ACC_W-1:0] sat_max;
    logic [ACC_W-1:0] sat_min;

    assign sat_max = {1'b0, {(ACC_W-1){1'b1}}};
    assign sat_min = {1'b1, {(ACC_W-1){1'b0}}};

    // On overflow both operands share a sign, so acc's sign gives the direction.
    always_comb begin
        sum = sum_raw;
        if (ovf) begin
            sum = acc[ACC_W-1] ? sat_min : sat_max;
        end
    end
`else
    assign sum = sum_raw;
`endif

endmodule

// File: rtl/product_accumulator.sv
// Accumulates signed multiplier products into a wide sum and emits the group
// total through a one-entry registered output buffer when a beat is tagged last.
// Configuration macro: PRODUCT_ACC_SAT_EN - clamp the accumulator on overflow
// (handled inside acc_add_ovf); default build wraps and only flags out_ovf.
// Ports:
//   clk       in  1       rising-edge clock
//   rst       in  1       synchronous active-high reset
//   clear     in  1       abort current group (partial sum and count dropped)
//   in_valid  in  1       product beat valid
//   in_ready  out 1       beat can be accepted
//   in_data   in  PROD_W  signed product
//   in_last   in  1       final beat of the group
//   out_valid out 1       result valid
//   out_ready in  1       consumer takes the result
//   out_data  out ACC_W   signed group sum
//   out_count out CNT_W   beats in the group (saturating)
//   out_ovf   out 1       signed overflow seen anywhere in the group
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    if (ACC_W < PROD_W) begin : g_bad_width
        $error("product_accumulator: ACC_W must be >= PROD_W");
    end

    acc_state_e state_q, state_d;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             ovf_now;
    logic [CNT_W-1:0] cnt_inc;

    assign accept   = in_valid && in_ready;
    assign prod_ext = ACC_W'($signed(in_data));
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    acc_add_ovf #(
        .ACC_W(ACC_W)
    ) u_add (
        .acc (acc_q),
        .prod(prod_ext),
        .sum (sum),
        .ovf (ovf_now)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else if (accept) begin
            state_d = in_last ? StIdle : StAccum;
        end
    end

    // FSM: outputs. A held, unconsumed result blocks new beats.
    always_comb begin
        in_ready = !rst && !clear && !(out_valid_q && !out_ready);
    end

    // Accumulator, counter and sticky overflow.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear || (accept && in_last)) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            acc_d = sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | ovf_now;
        end
    end

    // Output buffer: drains on handshake, reloads on a last beat in the same
    // cycle. clear never reaches here (accept is already gated by it).
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && in_last) begin
            out_valid_d = 1'b1;
            out_data_d  = sum;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q | ovf_now;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 32x32 signed combinational multiplier. Consumes its 64-bit two's-complement product once per accepted beat.
- Sign-extends each product and sums it into a wide accumulator, for dot-product and MAC use.
- When a beat is tagged last, the running sum is emitted through a one-entry registered output buffer with a valid/ready handshake.

Parameters:
- PROD_W, 64, product width (signed, matches multiplier output).
- ACC_W, 72, accumulator/result width; must be greater than or equal to PROD_W.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous abort: drops the partial sum and count
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  PROD_W  signed product from the multiplier
- in_last  in  1  final beat of the current group
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  ACC_W  signed group sum
- out_count  out  CNT_W  number of beats in the group
- out_ovf  out  1  signed overflow occurred in the group

Behaviour:
- Interface (decided): one clock, clk; synchronous active-high reset, rst.
- Reset values:
  - out_valid=0, out_data=0, out_count=0, out_ovf=0.
  - acc=0, cnt=0, ovf_sticky=0, state=IDLE.
  - in_ready=0 while rst=1.
- Handshake and readiness:
  - in_ready = !rst && !clear && !(out_valid && !out_ready).
  - A beat is accepted when in_valid && in_ready.
- State machine: IDLE (no beats) and ACCUM (one or more beats).
  - IDLE -> ACCUM on an accepted beat with in_last=0.
  - ACCUM -> IDLE on an accepted beat with in_last=1, or on clear.
  - A last beat accepted in IDLE produces a 1-beat group and stays in IDLE.
- Arithmetic:
  - sum = acc + sign_extend(in_data to ACC_W).
  - Overflow occurs when both operand signs are equal and the sum sign differs; ovf_sticky ORs this in.
  - Without saturation the sum wraps modulo 2^ACC_W.
  - cnt increments per beat and saturates at 2^CNT_W-1.
- Non-last beat: acc<=sum, cnt<=cnt+1.
- Last beat:
  - On the next edge, out_data<=sum, out_count<=cnt+1 (saturating), out_ovf<=ovf_sticky|ovf_now, out_valid<=1.
  - acc, cnt and ovf_sticky return to 0.
  - Latency from the last accepted beat to out_valid is 1 cycle.
- Output buffer:
  - out_valid drops on out_valid && out_ready unless a new last beat is accepted in the same cycle; in that case the buffer reloads and out_valid stays 1.
  - Back-to-back 1-beat groups sustain full throughput when out_ready=1.
  - out_* fields stay stable while out_valid && !out_ready.
- clear:
  - Zeroes acc, cnt and ovf_sticky, and sets state=IDLE.
  - Never touches a held output.
  - Forces in_ready=0, so a beat presented in the same cycle is not accepted.
- rst mid-group or mid-hold discards everything, including a pending result.

Optional Feature:
- PRODUCT_ACC_SAT_EN defined: on overflow the accumulator clamps.
  - Positive overflow clamps to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1).
  - The clamp applies both to acc and to the emitted out_data.
  - out_ovf is still reported.
- Undefined: the sum wraps two's-complement and only out_ovf flags the overflow.

Decomposition:
- Package product_acc_pkg holds:
  - the state enum {IDLE, ACCUM};
  - default width constants PROD_W_DEF=64, ACC_W_DEF=72, CNT_W_DEF=16;
  - the saturation bound constants.
- One sub-module, acc_add_ovf: combinational ACC_W signed adder.
  - Inputs: acc and the sign-extended product.
  - Outputs: sum and ovf; the clamp is applied inside when PRODUCT_ACC_SAT_EN is defined.
- FSM, counter and output buffer live in the top module.

Test Plan:
- Reset then a 3-beat group, out_ready=1:
  - Beats 3, 0xFFFF_FFFF_FFFF_FFFB (-5), and 7 with last.
  - Required: out_valid one cycle after the last beat, out_data=5, out_count=3, out_ovf=0.
- Backpressure:
  - Hold out_ready=0 after a 1-beat group of value 0x10, then present the next last beat.
  - Required: in_ready=0, out_data held at 0x10. When out_ready=1, the new last beat is accepted in that same cycle and out_data reloads next cycle.
- Clear mid-group:
  - Beats 100 and 200, then clear, then beat 1 with last.
  - Required: out_data=1, out_count=1. A beat presented with clear is not accepted.
- Overflow with ACC_W=PROD_W=64:
  - Two beats of 0x7FFF_FFFF_FFFF_FFFF, the second with last.
  - Without the macro: out_data=0xFFFF_FFFF_FFFF_FFFE, out_ovf=1.
  - With PRODUCT_ACC_SAT_EN: out_data=0x7FFF_FFFF_FFFF_FFFF, out_ovf=1.
- Reset mid-hold:
  - Assert rst while out_valid=1 and out_ready=0.
  - Required: next cycle out_valid=0, out_data=0, in_ready=0 during rst, in_ready=1 the cycle after rst deasserts.
- Throughput:
  - 8 consecutive 1-beat groups of values 1..8 with out_ready=1.
  - Required: 8 results on 8 consecutive cycles, each out_count=1.
